rock_mover: RTL and testbench



---
 rtl/rock_mover_pkg.sv | 22 ++
 rtl/rock_mover_lfsr16.sv | 17 +
 rtl/rock_mover.sv | 110 +++++++++++
 tb/tb_rock_mover.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rock_mover_pkg.sv
// Shared constants and state encoding for the rock spawner/mover.
// Screen geometry lives here so every spawner agrees on the playfield.
package rock_mover_pkg;
    localparam int SCREEN_W        = 640;
    localparam int SCREEN_H        = 480;
    localparam int ROCK_SIZE       = 25;
    localparam int FRAME_LINE      = 480;
    localparam int SPAWN_X         = SCREEN_W + ROCK_SIZE;
    localparam int Y_MIN           = 160;
    localparam int SPEED_INIT      = 2;
    localparam int SPEED_MAX       = 8;
    localparam int ROCKS_PER_LEVEL = 4;
    localparam int RESPAWN_FRAMES  = 30;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        WAIT = 2'd2
    } state_t;
endpackage

// File: rtl/rock_mover_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), one step per clock, never all-zero.
// State is registered; no handshake, it free-runs whenever out of reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
        end
    end
endmodule

// File: rtl/rock_mover.sv
// Rock position owner: moves the rock once per frame at the first blanking line, respawns after exit or hit.
// Outputs are registered and change only on the frame-tick edge; no backpressure.
module rock_mover
    import rock_mover_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [10:0] hcount,
    input  logic signed [10:0] vcount,
    input  logic               enable,
    input  logic               hit,
    output logic signed [11:0] rockX,
    output logic signed [11:0] rockY,
    output logic [7:0]         rocks_passed,
    output logic [3:0]         speed
);
    logic [15:0]        lfsr;
    logic               unused_lfsr_hi;
    state_t             state;
    logic               hit_pend;
    logic [4:0]         wait_cnt;
    logic [1:0]         level_cnt;
    logic               tick;
    logic               hit_any;
    logic signed [11:0] next_x;
    logic signed [11:0] spawn_y;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:8];

    assign tick    = (hcount == 11'sd0) && (vcount == 11'(FRAME_LINE));
    assign hit_any = hit | hit_pend;
    assign next_x  = rockX - $signed({8'd0, speed});
    assign spawn_y = 12'(Y_MIN) + {4'd0, lfsr[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rockX        <= 12'(SPAWN_X);
            rockY        <= 12'(Y_MIN);
            rocks_passed <= 8'd0;
            speed        <= 4'(SPEED_INIT);
            hit_pend     <= 1'b0;
            wait_cnt     <= 5'd0;
            level_cnt    <= 2'd0;
        end else begin
            if (hit) begin
                hit_pend <= 1'b1;
            end
            if (tick) begin
                // The tick consumes any pending hit, whatever state we are in.
                hit_pend <= 1'b0;
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state     <= MOVE;
                            speed     <= 4'(SPEED_INIT);
                            level_cnt <= 2'd0;
                            rockX     <= 12'(SPAWN_X);
                            rockY     <= spawn_y;
                        end
                    end
                    MOVE: begin
                        if (!enable) begin
                            state <= IDLE;
                            rockX <= 12'(SPAWN_X);
                        end else if (hit_any) begin
                            state    <= WAIT;
                            wait_cnt <= 5'(RESPAWN_FRAMES - 1);
                            rockX    <= 12'(SPAWN_X);
                        end else if (next_x[11]) begin
                            state     <= WAIT;
                            wait_cnt  <= 5'(RESPAWN_FRAMES - 1);
                            rockX     <= 12'(SPAWN_X);
                            level_cnt <= level_cnt + 2'd1;
                            if (rocks_passed != 8'hFF) begin
                                rocks_passed <= rocks_passed + 8'd1;
                            end
                            if (level_cnt == 2'(ROCKS_PER_LEVEL - 1) && speed < 4'(SPEED_MAX)) begin
                                speed <= speed + 4'd1;
                            end
                        end else begin
                            rockX <= next_x;
                        end
                    end
                    WAIT: begin
                        if (!enable) begin
                            state <= IDLE;
                        end else if (wait_cnt == 5'd0) begin
                            state <= MOVE;
                            rockX <= 12'(SPAWN_X);
                            rockY <= spawn_y;
                        end else begin
                            wait_cnt <= wait_cnt - 5'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        rockX <= 12'(SPAWN_X);
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rock_mover.sv
// Directed bench for rock_mover: table of per-frame vectors plus hand-written corner sequences.
module tb_rock_mover;
    logic               clk;
    logic               rst_n;
    logic signed [10:0] hcount;
    logic signed [10:0] vcount;
    logic               enable;
    logic               hit;
    logic signed [11:0] rockX;
    logic signed [11:0] rockY;
    logic [7:0]         rocks_passed;
    logic [3:0]         speed;

    int checks = 0;
    int errors = 0;
    int exp_y  = 160;
    int budget = 60000;
    logic [15:0] lfsr_m;
    logic [15:0] tick_lfsr;

    rock_mover dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hcount       (hcount),
        .vcount       (vcount),
        .enable       (enable),
        .hit          (hit),
        .rockX        (rockX),
        .rockY        (rockY),
        .rocks_passed (rocks_passed),
        .speed        (speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11 map to mask bits 15,13,12,10.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end

    typedef struct {
        logic en;
        int   n;
        int   x;
        int   passed;
        int   spd;
        logic spawn;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input int x, input int y, input int p, input int s);
        check({name, ".x"}, int'(rockX), x);
        check({name, ".y"}, int'(rockY), y);
        check({name, ".passed"}, int'(rocks_passed), p);
        check({name, ".speed"}, int'(speed), s);
    endtask

    task automatic tick(input logic with_hit);
        @(negedge clk);
        hcount    = 11'sd0;
        vcount    = 11'sd480;
        hit       = with_hit;
        tick_lfsr = lfsr_m;
        @(negedge clk);
        hcount = 11'sd5;
        vcount = 11'sd0;
        hit    = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick(1'b0);
    endtask

    task automatic pulse_hit();
        @(negedge clk);
        hcount = 11'sd100;
        vcount = 11'sd200;
        hit    = 1'b1;
        @(negedge clk);
        hit    = 1'b0;
        hcount = 11'sd5;
        vcount = 11'sd0;
    endtask

    task automatic wait_passed(input int target, input int exp_spd);
        while (int'(rocks_passed) != target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check($sformatf("run.passed%0d", target), int'(rocks_passed), target);
        check($sformatf("run.speed_at%0d", target), int'(speed), exp_spd);
    endtask

    initial begin
        rst_n  = 1'b0;
        hcount = 11'sd5;
        vcount = 11'sd0;
        enable = 1'b0;
        hit    = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 665, 160, 0, 2);
        rst_n = 1'b1;

        vecs[0] = '{1'b0, 1,   665, 0, 2, 1'b0};
        vecs[1] = '{1'b1, 1,   665, 0, 2, 1'b1};
        vecs[2] = '{1'b1, 3,   659, 0, 2, 1'b0};
        vecs[3] = '{1'b1, 29,  601, 0, 2, 1'b0};
        vecs[4] = '{1'b1, 100, 401, 0, 2, 1'b0};
        for (int i = 0; i < 5; i++) begin
            enable = vecs[i].en;
            ticks(vecs[i].n);
            if (vecs[i].spawn) exp_y = 160 + int'(tick_lfsr[7:0]);
            check_all($sformatf("vec%0d", i), vecs[i].x, exp_y, vecs[i].passed, vecs[i].spd);
            if (i == 3) begin
                // Active-video and near-miss counter values must not move the rock.
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    hcount = 11'(c * 37);
                    vcount = 11'(c * 25);
                end
                @(negedge clk); hcount = 11'sd0; vcount = 11'sd479;
                @(negedge clk); hcount = 11'sd1; vcount = 11'sd480;
                @(negedge clk); hcount = 11'sd5; vcount = 11'sd0;
                check("stable.x", int'(rockX), 601);
                check("stable.y", int'(rockY), exp_y);
            end
        end

        // Mid-line hit at x=401, then a hit during WAIT must not disturb respawn timing.
        pulse_hit();
        tick(1'b0);
        check_all("hit_mid", 665, exp_y, 0, 2);
        ticks(29);
        check("wait29.x", int'(rockX), 665);
        pulse_hit();
        tick(1'b0);
        exp_y = 160 + int'(tick_lfsr[7:0]);
        check_all("respawn_after_hit", 665, exp_y, 0, 2);
        tick(1'b0);
        check("move_after_respawn.x", int'(rockX), 663);

        // Exit at speed 2: x reaches 1, then 1-2 < 0 counts a pass.
        ticks(331);
        check("at_one.x", int'(rockX), 1);
        tick(1'b0);
        check_all("exit", 665, exp_y, 1, 2);
        ticks(29);
        check("exit_wait29.x", int'(rockX), 665);
        tick(1'b0);
        exp_y = 160 + int'(tick_lfsr[7:0]);
        check_all("exit_respawn", 665, exp_y, 1, 2);
        tick(1'b0);
        check("exit_move.x", int'(rockX), 663);

        // Hit on the same tick as the exit: hit wins, no count.
        ticks(331);
        check("at_one2.x", int'(rockX), 1);
        tick(1'b1);
        check_all("hit_exit", 665, exp_y, 1, 2);
        ticks(30);
        exp_y = 160 + int'(tick_lfsr[7:0]);
        ticks(5);
        check("after_hit_exit.x", int'(rockX), 655);
        check("after_hit_exit.y", int'(rockY), exp_y);

        // Enable drop during MOVE, stay parked, then re-enable.
        enable = 1'b0;
        tick(1'b0);
        check("disable.x", int'(rockX), 665);
        tick(1'b0);
        check("idle_hold.x", int'(rockX), 665);
        enable = 1'b1;
        tick(1'b0);
        exp_y = 160 + int'(tick_lfsr[7:0]);
        check_all("reenable", 665, exp_y, 1, 2);
        tick(1'b0);
        check("reenable_move.x", int'(rockX), 663);

        // Asynchronous reset away from any clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 665, 160, 0, 2);
        @(negedge clk);
        rst_n = 1'b1;

        // Tick every cycle to run many rocks through speed ramp and counter saturation.
        enable = 1'b1;
        @(negedge clk);
        hcount = 11'sd0;
        vcount = 11'sd480;
        wait_passed(3, 2);
        wait_passed(4, 3);
        wait_passed(8, 4);
        wait_passed(23, 7);
        wait_passed(24, 8);
        wait_passed(28, 8);
        wait_passed(255, 8);
        repeat (1200) @(negedge clk);
        check("saturate.passed", int'(rocks_passed), 255);
        check("saturate.speed", int'(speed), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
